// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM bridge: opcodes, frame field widths
// and the controller state encoding.
package spi_ram_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  localparam int OP_BITS   = 8;
  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_WDATA,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SHIFT,
    ST_DONE,
    ST_IGNORE
  } state_t;

  function automatic logic op_valid(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus edge strobes derived from the
// synchronised copies; strobes are valid for one clk.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_sync,
  output logic mosi_sync
);

  // Bit order {mosi, ss_n, sclk}; ss_n idles high so reset it high to avoid a false select.
  localparam logic [2:0] IDLE_VAL = 3'b010;

  logic [2:0] pins;
  logic [2:0] sync_vec;
  logic [2:0] last_vec;

  assign pins = {mosi, ss_n, sclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic last_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg <= IDLE_VAL[gi];
          sync_reg <= IDLE_VAL[gi];
          last_reg <= IDLE_VAL[gi];
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
          last_reg <= sync_reg;
        end
      end

      assign sync_vec[gi] = sync_reg;
      assign last_vec[gi] = last_reg;
    end
  endgenerate

  assign sclk_rise = sync_vec[0] & ~last_vec[0];
  assign sclk_fall = ~sync_vec[0] & last_vec[0];
  assign ss_fall   = ~sync_vec[1] & last_vec[1];
  assign ss_sync   = sync_vec[1];
  assign mosi_sync = sync_vec[2];

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI mode-0 slave that turns opcode/address/data frames into single-cycle
// accesses on a single-port RAM and returns read data on miso.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_SIZE    = 10,
  parameter int RD_LATENCY   = 2,
  parameter int PARITY_CHECK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_blk_select,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity,
  output logic                 busy,
  output logic                 err
);

  localparam int SHW = (MEM_WIDTH > ADDR_BITS) ? MEM_WIDTH : ADDR_BITS;
  localparam logic [4:0] OP_LAST   = 5'(OP_BITS - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(MEM_WIDTH - 1);
  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);

  logic sclk_rise, sclk_fall, ss_fall, ss_sync, mosi_sync;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_sync   (ss_sync),
    .mosi_sync (mosi_sync)
  );

  state_t               state_reg, state_next;
  logic [4:0]           cnt_reg, cnt_next;
  logic [SHW-1:0]       shift_reg, shift_next;
  logic [MEM_WIDTH-1:0] tx_reg, tx_next;
  logic [MEM_WIDTH-1:0] din_reg, din_next;
  logic [ADDR_SIZE-1:0] addr_reg, addr_next;
  logic [3:0]           wait_reg, wait_next;
  logic                 is_read_reg, is_read_next;
  logic                 miso_reg, miso_next;
  logic                 err_reg, err_next;
  logic                 wr_en_reg, rd_en_reg, blk_reg, addr_en_reg, dout_en_reg, busy_reg;

  logic [SHW-1:0] shifted;
  logic           parity_bad;

  assign shifted    = {shift_reg[SHW-2:0], mosi_sync};
  assign parity_bad = (PARITY_CHECK != 0) && (ram_parity != (^ram_dout));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    din_next     = din_reg;
    addr_next    = addr_reg;
    wait_next    = wait_reg;
    is_read_next = is_read_reg;
    miso_next    = miso_reg;
    err_next     = err_reg;

    case (state_reg)
      ST_IDLE: begin
        miso_next = 1'b0;
        if (ss_fall) begin
          state_next = ST_OPCODE;
          err_next   = 1'b0;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_OPCODE: begin
        if (ss_sync) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else if (sclk_rise) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 5'd1;
          if (cnt_reg == OP_LAST) begin
            cnt_next = '0;
            if (op_valid(shifted[OP_BITS-1:0])) begin
              state_next   = ST_ADDR;
              is_read_next = (shifted[OP_BITS-1:0] == OP_READ);
            end else begin
              state_next = ST_IGNORE;
              err_next   = 1'b1;
            end
          end
        end
      end
      ST_ADDR: begin
        if (ss_sync) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else if (sclk_rise) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 5'd1;
          if (cnt_reg == ADDR_LAST) begin
            cnt_next   = '0;
            addr_next  = shifted[ADDR_SIZE-1:0];
            state_next = is_read_reg ? ST_RD_ISSUE : ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (ss_sync) begin
          state_next = ST_IDLE;
          err_next   = 1'b1;
        end else if (sclk_rise) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 5'd1;
          if (cnt_reg == DATA_LAST) begin
            cnt_next   = '0;
            din_next   = shifted[MEM_WIDTH-1:0];
            state_next = ST_WR_ISSUE;
          end
        end
      end
      ST_WR_ISSUE: state_next = ST_DONE;
      ST_RD_ISSUE: begin
        wait_next  = '0;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        wait_next = wait_reg + 4'd1;
        if (wait_reg == WAIT_LAST) begin
          tx_next  = ram_dout;
          cnt_next = '0;
          // A deselect during the wait lets the RAM cycle finish but drops the result.
          if (ss_sync) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_RD_SHIFT;
            if (parity_bad) err_next = 1'b1;
          end
        end
      end
      ST_RD_SHIFT: begin
        if (ss_sync) begin
          state_next = ST_IDLE;
          miso_next  = 1'b0;
        end else begin
          if (sclk_fall) begin
            miso_next = tx_reg[MEM_WIDTH-1];
            tx_next   = {tx_reg[MEM_WIDTH-2:0], 1'b0};
          end
          // Leave on the rise where the master samples the last bit.
          if (sclk_rise) begin
            cnt_next = cnt_reg + 5'd1;
            if (cnt_reg == DATA_LAST) begin
              state_next = ST_DONE;
              miso_next  = 1'b0;
            end
          end
        end
      end
      ST_DONE, ST_IGNORE: begin
        miso_next = 1'b0;
        if (ss_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      tx_reg      <= '0;
      din_reg     <= '0;
      addr_reg    <= '0;
      wait_reg    <= '0;
      is_read_reg <= 1'b0;
      miso_reg    <= 1'b0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      blk_reg     <= 1'b0;
      addr_en_reg <= 1'b0;
      dout_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      din_reg     <= din_next;
      addr_reg    <= addr_next;
      wait_reg    <= wait_next;
      is_read_reg <= is_read_next;
      miso_reg    <= miso_next;
      err_reg     <= err_next;
      // Strobes are registered from the next state so they never glitch.
      wr_en_reg   <= (state_next == ST_WR_ISSUE);
      rd_en_reg   <= (state_next == ST_RD_ISSUE);
      blk_reg     <= (state_next == ST_WR_ISSUE) || (state_next == ST_RD_ISSUE);
      addr_en_reg <= (state_next == ST_WR_ISSUE);
      dout_en_reg <= (state_next == ST_RD_WAIT);
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign miso           = miso_reg;
  assign ram_din        = din_reg;
  assign ram_addr       = addr_reg;
  assign ram_wr_en      = wr_en_reg;
  assign ram_rd_en      = rd_en_reg;
  assign ram_blk_select = blk_reg;
  assign ram_addr_en    = addr_en_reg;
  assign ram_dout_en    = dout_en_reg;
  assign busy           = busy_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: bit-banged SPI master, behavioural RAM with
// two-stage read pipeline, and per-scenario checks against hand-computed values.
module tb_spi_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] ram_din;
  logic [9:0]  ram_addr;
  logic        ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en;
  logic [15:0] ram_dout;
  logic        ram_parity;
  logic        busy, err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(
    .MEM_WIDTH(16), .ADDR_SIZE(10), .RD_LATENCY(2), .PARITY_CHECK(1)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
    .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
    .ram_dout(ram_dout), .ram_parity(ram_parity), .busy(busy), .err(err)
  );

  // RAM model: address register stage then dout pipeline stage.
  logic [15:0] mem [0:1023];
  logic [15:0] st1 = 16'h0000;
  logic [15:0] st2 = 16'h0000;
  logic        par_flip = 1'b0;

  always @(posedge clk) begin
    if (ram_wr_en && ram_blk_select) mem[ram_addr] <= ram_din;
    if (ram_rd_en && ram_blk_select) st1 <= mem[ram_addr];
    if (ram_dout_en) st2 <= st1;
  end
  assign ram_dout   = st2;
  assign ram_parity = (^st2) ^ par_flip;

  // Strobe monitor.
  int          wr_cnt = 0, rd_cnt = 0;
  logic [9:0]  wr_addr, rd_addr;
  logic [15:0] wr_din;
  logic        wr_ctl_ok, rd_ctl_ok;

  always @(negedge clk) begin
    if (ram_wr_en) begin
      wr_cnt++;
      wr_addr   = ram_addr;
      wr_din    = ram_din;
      wr_ctl_ok = ram_blk_select && ram_addr_en && !ram_rd_en && !ram_dout_en;
    end
    if (ram_rd_en) begin
      rd_cnt++;
      rd_addr   = ram_addr;
      rd_ctl_ok = ram_blk_select && !ram_addr_en && !ram_wr_en;
    end
  end

  logic [15:0] rx_bits;

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0;
    wr_addr = '0; rd_addr = '0; wr_din = '0;
    wr_ctl_ok = 1'b0; rd_ctl_ok = 1'b0;
    rx_bits = '0;
  endtask

  task automatic spi_begin();
    @(negedge clk);
    sclk = 1'b0;
    ss_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Sends the first n bits of data (MSB first), sampling miso before each rise.
  task automatic spi_bits(input int n, input logic [39:0] data);
    for (int i = 0; i < n; i++) begin
      mosi = data[39-i];
      repeat (5) @(negedge clk);
      rx_bits = {rx_bits[14:0], miso};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    repeat (3) @(negedge clk);
    ctl = {miso, ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en, busy, err};
    chk_cnt++; if (ctl !== 8'h00) $display("FAIL reset_ctl got %b want 00000000", ctl); else pass_cnt++;
    chk_cnt++; if (ram_addr !== 10'h000) $display("FAIL reset_addr got %h want 000", ram_addr); else pass_cnt++;
    chk_cnt++; if (ram_din !== 16'h0000) $display("FAIL reset_din got %h want 0000", ram_din); else pass_cnt++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    $display("reset: ctl=%b addr=%h din=%h", ctl, ram_addr, ram_din);
  endtask

  task automatic test_write();
    clear_mon();
    spi_begin();
    spi_bits(40, 40'h02_0005_ABCD);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL write_busy got %b want 1", busy); else pass_cnt++;
    spi_end();
    chk_cnt++; if (wr_cnt !== 1) $display("FAIL write_count got %0d want 1", wr_cnt); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 10'h005) $display("FAIL write_addr got %h want 005", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_din !== 16'hABCD) $display("FAIL write_din got %h want abcd", wr_din); else pass_cnt++;
    chk_cnt++; if (wr_ctl_ok !== 1'b1) $display("FAIL write_ctl got %b want 1", wr_ctl_ok); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 0) $display("FAIL write_rdcount got %0d want 0", rd_cnt); else pass_cnt++;
    chk_cnt++; if ({busy, err} !== 2'b00) $display("FAIL write_end got busy,err=%b want 00", {busy, err}); else pass_cnt++;
    $display("write 02_0005_abcd: wr=%0d addr=%h din=%h err=%b", wr_cnt, wr_addr, wr_din, err);
  endtask

  task automatic test_read();
    clear_mon();
    spi_begin();
    spi_bits(40, 40'h03_0005_0000);
    spi_end();
    chk_cnt++; if (rd_cnt !== 1) $display("FAIL read_count got %0d want 1", rd_cnt); else pass_cnt++;
    chk_cnt++; if (wr_cnt !== 0) $display("FAIL read_wrcount got %0d want 0", wr_cnt); else pass_cnt++;
    chk_cnt++; if (rd_addr !== 10'h005) $display("FAIL read_addr got %h want 005", rd_addr); else pass_cnt++;
    chk_cnt++; if (rd_ctl_ok !== 1'b1) $display("FAIL read_ctl got %b want 1", rd_ctl_ok); else pass_cnt++;
    chk_cnt++; if (rx_bits !== 16'hABCD) $display("FAIL read_miso got %h want abcd", rx_bits); else pass_cnt++;
    chk_cnt++; if ({miso, err} !== 2'b00) $display("FAIL read_end got miso,err=%b want 00", {miso, err}); else pass_cnt++;
    $display("read 03_0005: rd=%0d miso=%h err=%b", rd_cnt, rx_bits, err);
  endtask

  task automatic test_bad_opcode();
    clear_mon();
    spi_begin();
    spi_bits(40, 40'h7F_0005_1234);
    chk_cnt++; if ({busy, err} !== 2'b11) $display("FAIL badop_active got busy,err=%b want 11", {busy, err}); else pass_cnt++;
    spi_end();
    chk_cnt++; if ({busy, err} !== 2'b01) $display("FAIL badop_end got busy,err=%b want 01", {busy, err}); else pass_cnt++;
    chk_cnt++; if (wr_cnt + rd_cnt !== 0) $display("FAIL badop_strobes got %0d want 0", wr_cnt + rd_cnt); else pass_cnt++;
    spi_begin();
    chk_cnt++; if (err !== 1'b0) $display("FAIL badop_clear got %b want 0", err); else pass_cnt++;
    spi_bits(40, 40'h02_0007_1111);
    spi_end();
    chk_cnt++; if (wr_cnt !== 1 || wr_din !== 16'h1111 || err !== 1'b0)
      $display("FAIL badop_recover got wr=%0d din=%h err=%b want 1 1111 0", wr_cnt, wr_din, err);
    else pass_cnt++;
    $display("bad opcode 7f: err cleared on next frame, recovery wr=%0d", wr_cnt);
  endtask

  task automatic test_short_write();
    clear_mon();
    spi_begin();
    spi_bits(20, 40'h02_0005_0000);
    spi_end();
    chk_cnt++; if (wr_cnt !== 0) $display("FAIL short_wrcount got %0d want 0", wr_cnt); else pass_cnt++;
    chk_cnt++; if ({busy, err} !== 2'b01) $display("FAIL short_state got busy,err=%b want 01", {busy, err}); else pass_cnt++;
    $display("short write (12 addr bits): wr=%0d err=%b", wr_cnt, err);
  endtask

  task automatic test_parity();
    clear_mon();
    par_flip = 1'b1;
    spi_begin();
    spi_bits(40, 40'h03_0005_0000);
    spi_end();
    par_flip = 1'b0;
    chk_cnt++; if (rx_bits !== 16'hABCD) $display("FAIL parity_miso got %h want abcd", rx_bits); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1) $display("FAIL parity_err got %b want 1", err); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 1) $display("FAIL parity_count got %0d want 1", rd_cnt); else pass_cnt++;
    $display("parity-flipped read: miso=%h err=%b", rx_bits, err);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    spi_begin();
    spi_bits(40, 40'h02_FFFF_8001);
    spi_end();
    spi_begin();
    spi_bits(40, 40'h03_03FF_0000);
    spi_end();
    chk_cnt++; if (wr_addr !== 10'h3FF) $display("FAIL b2b_wraddr got %h want 3ff", wr_addr); else pass_cnt++;
    chk_cnt++; if (rd_addr !== 10'h3FF) $display("FAIL b2b_rdaddr got %h want 3ff", rd_addr); else pass_cnt++;
    chk_cnt++; if (rx_bits !== 16'h8001) $display("FAIL b2b_miso got %h want 8001", rx_bits); else pass_cnt++;
    chk_cnt++; if ({wr_cnt, rd_cnt} !== {32'd1, 32'd1}) $display("FAIL b2b_counts got wr=%0d rd=%0d want 1 1", wr_cnt, rd_cnt); else pass_cnt++;
    $display("top address 3ff: wrote 8001, read back %h", rx_bits);
  endtask

  task automatic test_reset_mid();
    logic [33:0] outs;
    clear_mon();
    spi_begin();
    spi_bits(32, 40'h02_0123_5A5A);
    chk_cnt++; if ({busy, ram_addr} !== {1'b1, 10'h123}) $display("FAIL midrst_pre got busy=%b addr=%h want 1 123", busy, ram_addr); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    outs = {miso, ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en, busy, err, ram_addr, ram_din};
    chk_cnt++; if (outs !== 34'h0) $display("FAIL midrst_outs got %h want 0", outs); else pass_cnt++;
    #10;
    rst  = 1'b1;
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_cnt !== 0) $display("FAIL midrst_nowrite got %0d want 0", wr_cnt); else pass_cnt++;
    spi_begin();
    spi_bits(40, 40'h02_0123_5A5A);
    spi_end();
    chk_cnt++; if (wr_cnt !== 1 || wr_addr !== 10'h123 || wr_din !== 16'h5A5A || err !== 1'b0)
      $display("FAIL midrst_recover got wr=%0d addr=%h din=%h err=%b want 1 123 5a5a 0", wr_cnt, wr_addr, wr_din, err);
    else pass_cnt++;
    $display("mid-frame reset: outputs=%h, recovery wr=%0d din=%h", outs, wr_cnt, wr_din);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_short_write();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- SPI mode-0 slave that decodes serial frames into single-cycle write/read accesses on the team's parameterised single-port RAM (16-bit word, 10-bit address, optional address/dout pipelines, parity output).
- Sits directly upstream of the RAM: drives its din/addr/wr_en/rd_en/blk_select/addr_en/dout_en, consumes its dout/parity_out and shifts read data back on MISO.
- Entirely in the clk domain: SPI pins are oversampled (sclk ≤ clk/8).

Parameters:
- MEM_WIDTH, 16, RAM word width; SPI data field width.
- ADDR_SIZE, 10, RAM address width; low ADDR_SIZE bits of the 16-bit address field are used.
- RD_LATENCY, 2, clk cycles from rd_en pulse to valid RAM dout (1 = no dout pipeline, 2 = pipelined).
- PARITY_CHECK, 1, when 1, compare RAM parity_out against recomputed ^ram_dout on every read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, idle low.
- ss_n  in  1  SPI select, active low.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- ram_din  out  MEM_WIDTH  write data to RAM.
- ram_addr  out  ADDR_SIZE  address to RAM.
- ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en  out  1 each  RAM controls.
- ram_dout  in  MEM_WIDTH  RAM read data.
- ram_parity  in  1  RAM parity_out.
- busy  out  1  high from first command bit until frame end.
- err  out  1  sticky: bad opcode, short frame or parity mismatch; cleared by next ss_n falling edge.

Behaviour:
- Synchroniser: sclk, ss_n, mosi each through 2 flops; sclk rise/fall detected on synchronised copies (edge strobe 3 clk after pin edge).
- Frame: 8-bit opcode, 16-bit address, then 16-bit data (write: mosi in; read: miso out). Opcodes: 8'h02 write, 8'h03 read; any other -> err=1, FSM to IGNORE until ss_n high.
- Shift-in on sclk rise; miso updates on sclk fall; miso=0 outside READ shift.
- FSM: IDLE -> (ss_n fall) OPCODE -> (8 bits) ADDR -> (16 bits) WDATA or RD_ISSUE.
- WDATA -> (16 bits) WR_ISSUE: one clk with ram_wr_en=ram_blk_select=ram_addr_en=1, ram_addr/ram_din held -> DONE.
- RD_ISSUE: one clk ram_rd_en=ram_blk_select=1, ram_addr_en=0 -> RD_WAIT for RD_LATENCY clk (ram_dout_en=1 throughout) -> latch ram_dout into tx shifter, parity check -> RD_SHIFT (16 sclk falls) -> DONE.
- Master must allow ≥ RD_LATENCY+2 clk between the 24th sclk rise and first data-phase sclk fall; first data bit is driven on that fall.
- DONE/IGNORE -> IDLE when synchronised ss_n high.
- ss_n high in OPCODE/ADDR/WDATA/RD_SHIFT: abort to IDLE, no RAM write, err=1 if fewer than 24 bits were received (write aborted after address also sets err). Abort during RD_WAIT completes the read cycle silently.
- Extra sclk edges in DONE ignored. ss_n fall while not IDLE impossible (must rise first).
- RAM control strobes are single-cycle and mutually exclusive; ram_addr/ram_din change only in IDLE->OPCODE or on capture.
- Reset (any time, incl. mid-frame): FSM IDLE, all ram_* outputs 0, miso=0, busy=0, err=0, shifters/counters 0; no RAM strobe may glitch.
- Parity mismatch: err=1, data still shifted out.

Decomposition:
- Package spi_ram_pkg: opcode constants OP_WRITE=8'h02, OP_READ=8'h03, FSM state encoding, frame field widths (8/16/16).
- One sub-module: spi_sync_edge (2-flop sync of sclk/ss_n/mosi plus rise/fall/ss-fall strobes).

Test Plan:
- Write frame 02_0005_ABCD -> exactly one clk with wr_en=blk_select=addr_en=1, ram_addr=10'h005, ram_din=16'hABCD; err=0.
- Read frame 03_0005 with RAM model returning 16'hABCD after RD_LATENCY=2 -> single rd_en pulse, miso shifts 1010_1011_1100_1101 MSB first.
- Opcode 8'h7F -> no RAM strobes, err=1, busy until ss_n high; next ss_n fall clears err.
- ss_n raised after 12 address bits of a write -> IDLE, no wr_en, err=1.
- Read with ram_parity forced inverted -> err=1, data still 16'hABCD on miso.
- rst low mid write data phase -> all outputs 0 immediately (async); next full write frame succeeds.
